// File: rtl/pixel_word_packer_if.sv
// Pixel-in / word-out handshake bundle for pixel_word_packer.
// master: the side that feeds pixels and consumes words (testbench / system).
// slave:  the packer itself.
interface pixel_word_packer_if;
  logic [7:0]  pixel_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] word_out;
  logic [3:0]  byte_en;
  logic        eol;
  logic        eof;
  logic        valid_out;
  logic        ready_in;

  modport master (
    output pixel_in, valid_in, ready_in,
    input  ready_out, word_out, byte_en, eol, eof, valid_out
  );

  modport slave (
    input  pixel_in, valid_in, ready_in,
    output ready_out, word_out, byte_en, eol, eof, valid_out
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs an 8-bit pixel stream into 32-bit little-endian words with byte
// enables and end-of-line / end-of-frame markers. A word never spans lines;
// the last word of a line is partial when IMG_WIDTH is not a multiple of 4.
module pixel_word_packer #(
  parameter int IMG_WIDTH  = 1024,
  parameter int IMG_HEIGHT = 1024,
  parameter int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  parameter int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic clk,
  input  logic rst,
  pixel_word_packer_if.slave bus
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  logic [23:0]   acc;
  logic [1:0]    lane;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic [31:0] word_q;
  logic [3:0]  be_q;
  logic        eol_q;
  logic        eof_q;
  logic        valid_q;

  logic        ready;
  logic        accept;
  logic        last_x;
  logic        last_y;
  logic        complete;
  logic [31:0] word_next;
  logic [3:0]  be_next;

  assign ready    = !rst && (!valid_q || bus.ready_in);
  assign accept   = bus.valid_in && ready;
  assign last_x   = (x == X_LAST);
  assign last_y   = (y == Y_LAST);
  assign complete = accept && ((lane == 2'd3) || last_x);

  // Assemble the outgoing word: current pixel in the current lane, lower
  // lanes from the accumulator, unfilled upper lanes zero.
  always_comb begin
    word_next = '0;
    be_next   = '0;
    case (lane)
      2'd0: begin
        word_next = {24'h0, bus.pixel_in};
        be_next   = 4'b0001;
      end
      2'd1: begin
        word_next = {16'h0, bus.pixel_in, acc[7:0]};
        be_next   = 4'b0011;
      end
      2'd2: begin
        word_next = {8'h0, bus.pixel_in, acc[15:0]};
        be_next   = 4'b0111;
      end
      default: begin
        word_next = {bus.pixel_in, acc};
        be_next   = 4'b1111;
      end
    endcase
  end

  // Output register: a newly completed word wins over a same-cycle transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      be_q    <= '0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (complete) begin
      word_q  <= word_next;
      be_q    <= be_next;
      eol_q   <= last_x;
      eof_q   <= last_x && last_y;
      valid_q <= 1'b1;
    end else if (valid_q && bus.ready_in) begin
      valid_q <= 1'b0;
    end
  end

  // Accumulator and lane counter; lane restarts after every emitted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      if (complete) begin
        lane <= '0;
      end else begin
        case (lane)
          2'd0:    acc[7:0]   <= bus.pixel_in;
          2'd1:    acc[15:8]  <= bus.pixel_in;
          default: acc[23:16] <= bus.pixel_in;
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

  // Line / frame position, advanced once per accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (accept) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign bus.ready_out = ready;
  assign bus.word_out  = word_q;
  assign bus.byte_en   = be_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_pixel_word_packer.sv
// Randomized and directed bench for pixel_word_packer (IMG_WIDTH=6,
// IMG_HEIGHT=2) against a queue-based reference model of the packing rules.
module tb_pixel_word_packer;

  localparam int W = 6;
  localparam int H = 2;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  be;
    logic        eol;
    logic        eof;
  } wrd_t;

  logic clk;
  logic rst;

  pixel_word_packer_if bus ();

  pixel_word_packer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  src_q[$];
  logic [7:0]  pend[$];
  wrd_t        exp_q[$];
  wrd_t        obs_log[$];
  int unsigned p = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel index within the frame gives x,y; a word closes
  // after four pixels or at the end of a line.
  task automatic model_accept(input logic [7:0] pix);
    int unsigned x;
    int unsigned y;
    wrd_t e;
    x = p % W;
    y = p / W;
    pend.push_back(pix);
    p = (p + 1) % (W * H);
    if (pend.size() == 4 || x == W - 1) begin
      e.w = '0;
      for (int i = 0; i < pend.size(); i++) e.w[8*i +: 8] = pend[i];
      e.be  = 4'((1 << pend.size()) - 1);
      e.eol = (x == W - 1);
      e.eof = e.eol && (y == H - 1);
      exp_q.push_back(e);
      pend.delete();
    end
  endtask

  // One clock: drive after the rising edge, check and update model at the falling edge.
  task automatic step(input logic v, input logic r);
    logic acc;
    logic xfer;
    wrd_t o;
    @(posedge clk);
    #1;
    bus.valid_in = v && (src_q.size() > 0);
    bus.pixel_in = (src_q.size() > 0) ? src_q[0] : 8'h00;
    bus.ready_in = r;
    @(negedge clk);
    check("valid_out", 32'(bus.valid_out), 32'(exp_q.size() != 0));
    check("ready_out", 32'(bus.ready_out), 32'((exp_q.size() == 0) || r));
    if (exp_q.size() != 0) begin
      check("word_out", bus.word_out, exp_q[0].w);
      check("byte_en", 32'(bus.byte_en), 32'(exp_q[0].be));
      check("eol", 32'(bus.eol), 32'(exp_q[0].eol));
      check("eof", 32'(bus.eof), 32'(exp_q[0].eof));
    end
    acc  = bus.valid_in && ((exp_q.size() == 0) || bus.ready_in);
    xfer = (exp_q.size() != 0) && bus.ready_in;
    if (xfer) begin
      o.w = bus.word_out; o.be = bus.byte_en; o.eol = bus.eol; o.eof = bus.eof;
      obs_log.push_back(o);
      void'(exp_q.pop_front());
    end
    if (acc) begin
      model_accept(src_q[0]);
      void'(src_q.pop_front());
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid_in = 1'b1;
    bus.ready_in = 1'b1;
    exp_q.delete();
    pend.delete();
    src_q.delete();
    p = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("rst_ready_out", 32'(bus.ready_out), 32'd0);
      check("rst_valid_out", 32'(bus.valid_out), 32'd0);
      check("rst_word_out", bus.word_out, 32'd0);
      check("rst_byte_en", 32'(bus.byte_en), 32'd0);
      check("rst_eol_eof", 32'({bus.eol, bus.eof}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (src_q.size() != 0 || exp_q.size() != 0); k++) step(1'b1, 1'b1);
    check("drain_done", 32'(src_q.size() + exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] dir_w[4];
    logic [3:0]  dir_be[4];
    logic [1:0]  dir_m[4];
    rst = 1'b1;
    bus.pixel_in = 8'h00;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;

    do_reset(3);

    // Directed frame with partial end-of-line words.
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'hA0 + i));
    obs_log.delete();
    drain();
    dir_w  = '{32'hA3A2A1A0, 32'h0000A5A4, 32'hA9A8A7A6, 32'h0000ABAA};
    dir_be = '{4'hF, 4'h3, 4'hF, 4'h3};
    dir_m  = '{2'b00, 2'b10, 2'b00, 2'b11};
    check("dir_count", 32'(obs_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < obs_log.size(); i++) begin
      check("dir_word", obs_log[i].w, dir_w[i]);
      check("dir_be", 32'(obs_log[i].be), 32'(dir_be[i]));
      check("dir_eol_eof", 32'({obs_log[i].eol, obs_log[i].eof}), 32'(dir_m[i]));
    end

    // Backpressure: hold the first word for five cycles, then release.
    for (int i = 0; i < 12; i++) src_q.push_back(8'($urandom));
    for (int k = 0; k < 50 && exp_q.size() == 0; k++) step(1'b1, 1'b1);
    check("bp_word_seen", 32'(exp_q.size() != 0), 32'd1);
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    drain();

    // Randomized traffic across many lines and frames.
    for (int i = 0; i < 600; i++) src_q.push_back(8'($urandom));
    for (int k = 0; k < 1500 && src_q.size() != 0; k++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    drain();

    // Reset after three pixels of a line discards the partial word.
    for (int i = 0; i < 3; i++) src_q.push_back(8'($urandom));
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1);
    do_reset(2);
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h11 + i));
    obs_log.delete();
    drain();
    check("rst_resume_count", 32'(obs_log.size()), 32'd1);
    if (obs_log.size() != 0) begin
      check("rst_resume_word", obs_log[0].w, 32'h14131211);
      check("rst_resume_eol", 32'(obs_log[0].eol), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
